mr1_bus_responder: RTL
======================

Name: mr1_bus_responder

Overview:
- Bus-side responder for the MR1 formal harness. It sits directly downstream of the core's instruction and data request ports and produces ready/response handshakes from free-running random inputs.
- Enforces legal bus timing by construction: bounded outstanding reads, in-order responses, no response without a request, and optional fairness (bounded stalls).
- Flags core-side protocol violations on a sticky error output that the harness asserts low.

Parameters:
- MAX_OUTSTANDING, 2, max accepted-but-unanswered reads per bus (1..4); also the depth of each address FIFO.
- MAX_STALL, 3, with fairness on: max consecutive cycles a pending request waits for ready, or an outstanding read waits for a response.
- FAIRNESS, 1, 1 = force ready/valid once a stall counter reaches MAX_STALL; 0 = purely random.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_req_valid  in  1  core fetch request
- instr_req_addr  in  32  fetch address
- instr_req_ready  out  1  fetch request accepted
- instr_rsp_valid  out  1  fetch response
- instr_rsp_addr  out  32  address of the request being answered (FIFO head)
- data_req_valid  in  1  core load/store request
- data_req_wr  in  1  1 = store, 0 = load
- data_req_addr  in  32  data address
- data_req_size  in  2  access size
- data_req_data  in  32  store data
- data_req_ready  out  1  data request accepted
- data_rsp_valid  out  1  load response
- data_rsp_addr  out  32  address of the load being answered
- instr_ready_rand, instr_rsp_rand, data_ready_rand, data_rsp_rand  in  1 each  free random choices from the harness
- instr_out_cnt, data_out_cnt  out  3 each  current outstanding-read counts
- protocol_err  out  1  sticky core-protocol violation flag

Behaviour:
- Reset:
  - counts = 0, FIFOs empty, stall counters = 0, protocol_err = 0.
  - While reset is high, all ready and rsp_valid outputs are forced to 0.
  - Reset mid-transaction discards all outstanding entries; no response is produced for them.
- Instruction accept:
  - instr_req_ready = instr_req_valid && instr_out_cnt < MAX_OUTSTANDING && (instr_ready_rand || force_ready).
  - force_ready = FAIRNESS && req_stall_cnt == MAX_STALL.
  - req_stall_cnt increments each cycle with valid && !ready (saturates at MAX_STALL) and clears otherwise.
  - When the bus is full, ready stays 0 regardless of force_ready.
- Instruction response:
  - instr_rsp_valid = instr_out_cnt > 0 && (instr_rsp_rand || force_rsp).
  - force_rsp = FAIRNESS && rsp_wait_cnt == MAX_STALL.
  - rsp_wait_cnt counts cycles with instr_out_cnt > 0 && !instr_rsp_valid and clears on a response.
  - Uses the registered count, so minimum request-to-response latency is 1 cycle; no same-cycle response.
- Counters:
  - The count increments on accept and decrements on response.
  - Simultaneous accept and response leaves the count unchanged, with a push and a pop in the same cycle.
  - The count never exceeds MAX_OUTSTANDING and never underflows.
- Address FIFO:
  - Push instr_req_addr on accept; pop on response.
  - instr_rsp_addr = FIFO head.
  - Pointers wrap modulo MAX_OUTSTANDING; responses are strictly in order.
- Data bus:
  - Same accept, ready, fairness and response rules as the instruction bus, with independent counters.
  - Only loads (data_req_wr = 0) push the FIFO and increment data_out_cnt.
  - Stores complete on accept and never produce data_rsp_valid.
  - A store may be accepted when data_out_cnt == MAX_OUTSTANDING; a load may not.
- Protocol check, per bus:
  - Register "stalled_q" = valid && !ready, plus the request fields.
  - If stalled_q is set, the next cycle must have valid = 1 and addr (plus wr/size/data for the data bus) unchanged.
  - Any violation sets protocol_err = 1 on the next edge; it stays 1 until reset.
- All outputs other than the FIFO heads are combinational from registered state and the current inputs; no combinational path from core inputs to rsp_valid.

Test Plan:
- Fetch accepted at cycle 0 with addr 0x100 and instr_rsp_rand = 1 at cycles 0 and 1 -> no response at cycle 0; instr_rsp_valid = 1 with instr_rsp_addr = 0x100 at cycle 1; count goes 0→1→0.
- Two fetches accepted back to back (0x100, 0x104), MAX_OUTSTANDING = 2, third request pending -> ready = 0 while count = 2; responses arrive in order 0x100 then 0x104; wrap verified over 5 further pairs.
- FAIRNESS = 1, MAX_STALL = 3, ready_rand held 0 with valid held 1 -> ready forced high on the 4th cycle of the request; likewise rsp_rand held 0 -> response forced on the 4th waiting cycle.
- Data store at 0x200 then load at 0x204 -> store gives no response and data_out_cnt stays 0; load gives data_rsp_addr = 0x204; simultaneous load accept and response keeps the count at 1.
- Core drops valid, or changes addr 0x300→0x304, while stalled -> protocol_err = 1 the next cycle and stays 1; reset clears it and also empties FIFOs holding 2 outstanding entries, with no later rsp_valid for them.

Source files
------------

// File: rtl/mr1_bus_responder.sv
// MR1 formal-harness bus responder: random but legal ready/response timing for the
// instruction and data buses, in-order address FIFOs and a sticky core-protocol check.

module mr1_bus_responder #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int MAX_STALL       = 3,
  parameter int FAIRNESS        = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_valid,
  input  logic [31:0] instr_req_addr,
  output logic        instr_req_ready,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_addr,
  input  logic        data_req_valid,
  input  logic        data_req_wr,
  input  logic [31:0] data_req_addr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_data,
  output logic        data_req_ready,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_addr,
  input  logic        instr_ready_rand,
  input  logic        instr_rsp_rand,
  input  logic        data_ready_rand,
  input  logic        data_rsp_rand,
  output logic [2:0]  instr_out_cnt,
  output logic [2:0]  data_out_cnt,
  output logic        protocol_err
);

  localparam logic [2:0] MAX_CNT   = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] LAST_PTR  = 2'(MAX_OUTSTANDING - 1);
  localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);
  localparam logic       FAIR      = (FAIRNESS != 0);

  // Index 0 is the instruction bus, index 1 the data bus.
  logic [1:0]  req_valid, req_load, ready_rand, rsp_rand;
  logic [1:0]  req_ready, rsp_valid, violation;
  logic [31:0] req_addr [2];
  logic [66:0] req_fields [2];
  logic [31:0] head_addr [2];
  logic [2:0]  cnt [2];

  function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
    return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == STALL_LIM) ? value : value + 8'd1;
  endfunction

  // Stores complete on accept, so only loads occupy a FIFO slot on the data bus.
  assign req_valid     = {data_req_valid, instr_req_valid};
  assign req_load      = {!data_req_wr, 1'b1};
  assign ready_rand    = {data_ready_rand, instr_ready_rand};
  assign rsp_rand      = {data_rsp_rand, instr_rsp_rand};
  assign req_addr[0]   = instr_req_addr;
  assign req_addr[1]   = data_req_addr;
  assign req_fields[0] = {35'd0, instr_req_addr};
  assign req_fields[1] = {data_req_wr, data_req_size, data_req_data, data_req_addr};

  for (genvar b = 0; b < 2; b++) begin : g_bus
    logic [2:0]  cnt_q;
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0] fifo_q [4];
    logic [7:0]  req_stall_q, rsp_wait_q;
    logic        stalled_q;
    logic [66:0] fields_q;
    logic        force_ready, force_rsp, push, pop;

    assign force_ready  = FAIR && (req_stall_q == STALL_LIM);
    assign force_rsp    = FAIR && (rsp_wait_q == STALL_LIM);
    assign req_ready[b] = !reset && req_valid[b] && (!req_load[b] || (cnt_q < MAX_CNT))
                          && (ready_rand[b] || force_ready);
    // Built from the registered count only, so a request is never answered in its own cycle.
    assign rsp_valid[b] = !reset && (cnt_q != 3'd0) && (rsp_rand[b] || force_rsp);
    assign push         = req_ready[b] && req_load[b];
    assign pop          = rsp_valid[b];
    assign head_addr[b] = fifo_q[rd_ptr_q];
    assign cnt[b]       = cnt_q;
    assign violation[b] = stalled_q && (!req_valid[b] || (req_fields[b] != fields_q));

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q       <= 3'd0;
        wr_ptr_q    <= 2'd0;
        rd_ptr_q    <= 2'd0;
        req_stall_q <= 8'd0;
        rsp_wait_q  <= 8'd0;
        stalled_q   <= 1'b0;
        fields_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
        if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
        if (push && !pop) cnt_q <= cnt_q + 3'd1;
        else if (pop && !push) cnt_q <= cnt_q - 3'd1;
        req_stall_q <= (req_valid[b] && !req_ready[b]) ? sat_inc(req_stall_q) : 8'd0;
        rsp_wait_q  <= ((cnt_q != 3'd0) && !rsp_valid[b]) ? sat_inc(rsp_wait_q) : 8'd0;
        stalled_q   <= req_valid[b] && !req_ready[b];
        fields_q    <= req_fields[b];
      end
    end

    always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= req_addr[b];
    end
  end

  assign instr_req_ready = req_ready[0];
  assign instr_rsp_valid = rsp_valid[0];
  assign instr_rsp_addr  = head_addr[0];
  assign instr_out_cnt   = cnt[0];
  assign data_req_ready  = req_ready[1];
  assign data_rsp_valid  = rsp_valid[1];
  assign data_rsp_addr   = head_addr[1];
  assign data_out_cnt    = cnt[1];

  always_ff @(posedge clock) begin
    if (reset) protocol_err <= 1'b0;
    else if (|violation) protocol_err <= 1'b1;
  end

endmodule
